// File: rtl/wishbone_master_adapter_cpu.sv
// wishbone_master_adapter_cpu
// Bridges the CPU load/store request port onto a Wishbone classic
// single-transfer master. One transfer is in flight at a time. Each transfer
// ends with a one-cycle ready pulse (with err on timeout), followed by a
// guaranteed idle bus cycle.
//
// Ports
//   clk_i, rst          clock, synchronous active-high reset
//   cpu_req_i ..        CPU request: valid level, address, write data, we, byte enables
//   cpu_rdata_o         last read data, valid with cpu_ready_o
//   cpu_ready_o/err_o   one-cycle completion pulse / timeout flag
//   cpu_busy_o          high while a transfer or its response cycle is active
//   wb_*                Wishbone classic master signals
//
// state | meaning
// IDLE  | bus idle, waiting for cpu_req_i
// REQ   | CYC/STB asserted, waiting for ACK or timeout
// RESP  | ready/err pulse, bus forced idle for one cycle
module wishbone_master_adapter_cpu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cyc, cyc_nxt;
  logic [31:0]      addr_nxt, wdata_nxt, rdata_nxt;
  logic [3:0]       sel_nxt;
  logic             we_nxt, ready_nxt, err_nxt, busy_nxt;

  // CYC and STB are always equal for single classic transfers.
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cyc         <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= 4'h0;
      cpu_rdata_o <= '0;
      cpu_ready_o <= 1'b0;
      cpu_err_o   <= 1'b0;
      cpu_busy_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cyc         <= cyc_nxt;
      wb_addr_o   <= addr_nxt;
      wb_data_o   <= wdata_nxt;
      wb_we_o     <= we_nxt;
      wb_sel_o    <= sel_nxt;
      cpu_rdata_o <= rdata_nxt;
      cpu_ready_o <= ready_nxt;
      cpu_err_o   <= err_nxt;
      cpu_busy_o  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cyc_nxt   = cyc;
    addr_nxt  = wb_addr_o;
    wdata_nxt = wb_data_o;
    we_nxt    = wb_we_o;
    sel_nxt   = wb_sel_o;
    rdata_nxt = cpu_rdata_o;
    busy_nxt  = cpu_busy_o;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i) begin
          // word-align: the bus addresses words, lanes come from sel
          addr_nxt  = cpu_addr_i & 32'hFFFF_FFFC;
          wdata_nxt = cpu_wdata_i;
          we_nxt    = cpu_we_i;
          sel_nxt   = cpu_we_i ? cpu_be_i : 4'hF;
          cyc_nxt   = 1'b1;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // ACK takes priority over a timeout on the same edge
        if (wb_ack_i) begin
          if (!wb_we_o) rdata_nxt = wb_data_i;
          ready_nxt = 1'b1;
          cyc_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = RESP;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          if (!wb_we_o) rdata_nxt = '0;
          ready_nxt = 1'b1;
          err_nxt   = 1'b1;
          cyc_nxt   = 1'b0;
          we_nxt    = 1'b0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_master_adapter_cpu.sv
module tb_wishbone_master_adapter_cpu;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_be_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ready_o, cpu_err_o, cpu_busy_o;
  logic [31:0] wb_addr_o, wb_data_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int ready_cycle = 0;
  logic [31:0] model_rdata = '0;

  wishbone_master_adapter_cpu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o), .cpu_err_o(cpu_err_o),
    .cpu_busy_o(cpu_busy_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer. ack_at = STB cycle (1-based) in which the slave acks;
  // 0 or anything beyond TO means the slave never acks in time.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int ack_at, input logic [31:0] sdata,
                      input logic hold_req);
    bit acked;
    int stb_len;
    bit exp_err;
    acked   = (ack_at >= 1) && (ack_at <= TO);
    stb_len = acked ? ack_at : TO;
    exp_err = !acked;
    @(negedge clk_i);
    check("idle_stb", wb_stb_o, 1'b0);
    check("idle_busy", cpu_busy_o, 1'b0);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_be_i = be;
    for (int n = 1; n <= stb_len; n++) begin
      @(negedge clk_i);
      if (!hold_req) cpu_req_i = 1'b0;
      check("req_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
      check("req_addr", wb_addr_o, {addr[31:2], 2'b00});
      check("req_data", wb_data_o, wdata);
      check("req_sel", wb_sel_o, we ? be : 4'hF);
      check("req_we", wb_we_o, we);
      check("req_ready", cpu_ready_o, 1'b0);
      check("req_busy", cpu_busy_o, 1'b1);
      wb_ack_i  = (n == ack_at);
      wb_data_i = sdata;
    end
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    if (!we) model_rdata = acked ? sdata : 32'h0;
    ready_cycle = cycle;
    check("resp_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("resp_ready", cpu_ready_o, 1'b1);
    check("resp_err", cpu_err_o, exp_err);
    check("resp_busy", cpu_busy_o, 1'b1);
    check("resp_rdata", cpu_rdata_o, model_rdata);
  endtask

  initial begin
    int r0, r1, r2;
    repeat (3) @(negedge clk_i);
    rst = 1'b0;
    check("rst_outs", {wb_cyc_o, wb_stb_o, wb_we_o, cpu_ready_o, cpu_err_o, cpu_busy_o}, 6'b0);
    check("rst_addr", wb_addr_o, 32'h0);
    check("rst_data", wb_data_o, 32'h0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    check("rst_sel", wb_sel_o, 4'h0);

    // read, slave acks one cycle after seeing STB
    xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 1'b0);
    // write: rdata must stay at the previous read value
    xfer(1'b1, 32'h0000_2003, 32'h1234_5678, 4'b0011, 2, 32'hFFFF_0000, 1'b0);
    check("write_keeps_rdata", cpu_rdata_o, 32'hDEAD_BEEF);

    // back-to-back reads with request held high: 4-cycle period
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 2, 32'h1111_1111, 1'b1); r0 = ready_cycle;
    xfer(1'b0, 32'h0000_0014, 32'h0, 4'h0, 2, 32'h2222_2222, 1'b1); r1 = ready_cycle;
    xfer(1'b0, 32'h0000_0018, 32'h0, 4'h0, 2, 32'h3333_3333, 1'b1); r2 = ready_cycle;
    cpu_req_i = 1'b0;
    check("b2b_period1", r1 - r0, 4);
    check("b2b_period2", r2 - r1, 4);

    // timeout on a read, then ACK on the final permitted cycle
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_3004, 32'h0, 4'h0, TO, 32'hA5A5_A5A5, 1'b0);

    // spurious ACK while idle
    @(negedge clk_i);
    wb_ack_i = 1'b1; wb_data_i = 32'hBAD0_BAD0;
    repeat (2) begin
      @(negedge clk_i);
      check("spur_ready", {cpu_ready_o, cpu_busy_o, wb_stb_o}, 3'b000);
      check("spur_rdata", cpu_rdata_o, model_rdata);
    end
    wb_ack_i = 1'b0;

    // reset while STB high
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_4000;
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    check("pre_rst_stb", wb_stb_o, 1'b1);
    rst = 1'b1;
    @(negedge clk_i);
    rst = 1'b0;
    check("mid_rst", {wb_cyc_o, wb_stb_o, cpu_ready_o, cpu_err_o, cpu_busy_o}, 5'b0);
    model_rdata = 32'h0;
    check("mid_rst_rdata", cpu_rdata_o, model_rdata);
    xfer(1'b0, 32'h0000_4008, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0);

    // randomized transfers against the transaction-level model
    for (int i = 0; i < 24; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, TO + 2), $urandom, 1'($urandom_range(0, 1)));
    end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("final_idle", {cpu_busy_o, wb_stb_o, cpu_ready_o}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
